// File: rtl/add_arbiter_pkg.sv
// Shared types and helpers for the add_arbiter slice.
package add_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      CLEAR = 2'd2,
      WAIT  = 2'd3
   } state_t;

   localparam int DEFAULT_W = 32;

   // Width of a requester index; never less than one bit.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/add_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after
// `last`, wrapping modulo NREQ. `last` itself has the lowest priority.
module rr_pick
   import add_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = idx_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic            any,
   output logic [IW-1:0]   winner
);

   // Scan NREQ positions starting at last+1 and keep the first hit.
   always_comb begin
      int idx;
      idx    = 0;
      any    = 1'b0;
      winner = last;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last) + k) % NREQ;
         if (!any && req[idx]) begin
            any    = 1'b1;
            winner = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin sequencer sharing one start/done adder among NREQ requesters.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | sample req; capture the winner's operands on any request
//  ISSUE | one-cycle add_start and gnt pulse to the winner
//  CLEAR | wait for add_done low (adder accepted the new start;
//        | masks the sticky done left by the previous operation)
//  WAIT  | wait for add_done high, then register result and respond
module add_arbiter
   import add_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W    = DEFAULT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] a_in,
   input  logic [NREQ*W-1:0] b_in,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [W-1:0]      rsp_result,
   output logic              busy,
   output logic              add_start,
   output logic [W-1:0]      add_a,
   output logic [W-1:0]      add_b,
   input  logic [W-1:0]      add_result,
   input  logic              add_done
);

   localparam int IW = idx_width(NREQ);

   state_t        state, state_nxt;
   logic [IW-1:0] last;
   logic [IW-1:0] pick;
   logic          any;
   logic          capture;
   logic          respond;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req    (req),
      .last   (last),
      .any    (any),
      .winner (pick)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state and the combinational adder/grant controls.
   always_comb begin
      state_nxt = state;
      add_start = 1'b0;
      gnt       = '0;
      capture   = 1'b0;
      respond   = 1'b0;
      case (state)
         IDLE: begin
            if (any) begin
               capture   = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            add_start = 1'b1;
            gnt[last] = 1'b1;
            state_nxt = CLEAR;
         end
         CLEAR: begin
            if (!add_done) state_nxt = WAIT;
         end
         WAIT: begin
            if (add_done) begin
               respond   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // Operand capture, pointer update and registered response.
   always_ff @(posedge clk) begin
      if (reset) begin
         last       <= IW'(NREQ - 1);
         add_a      <= '0;
         add_b      <= '0;
         rsp_result <= '0;
         rsp_valid  <= '0;
      end else begin
         rsp_valid <= '0;
         if (capture) begin
            last  <= pick;
            add_a <= a_in[int'(pick)*W +: W];
            add_b <= b_in[int'(pick)*W +: W];
         end
         if (respond) begin
            rsp_result      <= add_result;
            rsp_valid[last] <= 1'b1;
         end
      end
   end

endmodule
